// File: rtl/pingpong_fb_pkg.sv
// Shared definitions for the ping-pong frame buffer: write-state encoding,
// drop counter width and the lane slicing helper.
package pingpong_fb_pkg;

  // Writer state: filling the back buffer, or holding a finished frame
  // until the reader allows a swap.
  typedef enum logic [0:0] {
    WR_FILL    = 1'b0,
    WR_PENDING = 1'b1
  } wr_state_t;

  // Width of the discarded-frame counter (only used with the drop option).
  localparam int DROP_COUNT_WIDTH = 16;

  // LSB position of a lane inside the packed multi-lane data word.
  function automatic int lane_lsb(input int lane, input int lane_width);
    return lane * lane_width;
  endfunction

endpackage

// File: rtl/pingpong_frame_buffer_ram.sv
// One lane of storage: simple dual-port, single clock, registered read.
// The two frame buffers live in one array, selected by the address MSB.
// A read flagged out-of-range loads zero instead of the array word; the
// read register holds its value while no read is issued.
module frame_buffer_ram #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic                  rd_sel,
  input  logic                  rd_zero,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  localparam int WORDS = 2 ** (ADDR_WIDTH + 1);

  logic [WIDTH-1:0] mem [WORDS];

  // Write port: buffer select forms the top address bit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_sel, wr_addr}] <= wr_data;
    end
  end

  // Registered read port; clears on reset, holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_zero ? '0 : mem[{rd_sel, rd_addr}];
    end
  end

endmodule

// File: rtl/pingpong_frame_buffer.sv
// Double-buffered frame store between a streaming writer and a random-access
// reader. One RAM bank per lane; the writer fills the back buffer, the reader
// reads the front buffer, and they swap once a frame is complete and the
// reader is not locked.
// Optional macro PINGPONG_DROP_ON_BUSY_EN: the writer is never stalled; a word
// arriving while a finished frame waits for a swap discards that frame and
// starts a new one, counted on O_drop_count.
module pingpong_frame_buffer
  import pingpong_fb_pkg::*;
#(
  parameter  int LANE_COUNT = 3,
  parameter  int LANE_WIDTH = 32,
  parameter  int DEPTH      = 480,
  localparam int DATA_WIDTH = LANE_COUNT * LANE_WIDTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                        I_clk,
  input  logic                        I_rst,
  input  logic                        I_wr_valid,
  output logic                        O_wr_ready,
  input  logic [DATA_WIDTH-1:0]       I_wr_data,
  input  logic                        I_wr_last,
  input  logic                        I_rd_en,
  input  logic [ADDR_WIDTH-1:0]       I_rd_addr,
  output logic [DATA_WIDTH-1:0]       O_rd_data,
  output logic                        O_rd_valid,
  input  logic                        I_rd_lock,
  output logic                        O_swap,
`ifdef PINGPONG_DROP_ON_BUSY_EN
  output logic [DROP_COUNT_WIDTH-1:0] O_drop_count,
`endif
  output logic                        O_frame_valid
);

  wr_state_t             state_reg;
  logic [ADDR_WIDTH-1:0] wr_addr_reg;
  logic                  front_sel_reg;
  logic                  swap_reg;
  logic                  frame_valid_reg;
  logic                  rd_valid_reg;

  logic wr_fire;
  logic swap_now;
  logic frame_end;
  logic ram_wr_sel;
  logic rd_zero;

  // A finished frame swaps in on any edge where the reader is unlocked.
  assign swap_now = (state_reg == WR_PENDING) && !I_rd_lock;

`ifdef PINGPONG_DROP_ON_BUSY_EN
  assign O_wr_ready = 1'b1;
`else
  assign O_wr_ready = (state_reg == WR_FILL);
`endif

  assign wr_fire   = I_wr_valid && O_wr_ready;
  // The last address always closes a frame so the writer can never overrun.
  assign frame_end = wr_fire && (I_wr_last || (wr_addr_reg == ADDR_WIDTH'(DEPTH - 1)));

  // On a swap edge the incoming word belongs to the buffer that is about to
  // become the back buffer, i.e. the current front.
  assign ram_wr_sel = swap_now ? front_sel_reg : ~front_sel_reg;

  // Widen by one bit so DEPTH itself is representable when it is a power of two.
  assign rd_zero = ({1'b0, I_rd_addr} >= (ADDR_WIDTH + 1)'(DEPTH));

  // Write FSM, write address counter and buffer select.
  // In PENDING the address is already zero, so a word accepted there (drop
  // option) simply starts a new frame at address 0 through the normal path.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_reg     <= WR_FILL;
      wr_addr_reg   <= '0;
      front_sel_reg <= 1'b0;
    end else begin
      if (swap_now) begin
        front_sel_reg <= ~front_sel_reg;
      end
      if (wr_fire) begin
        if (frame_end) begin
          wr_addr_reg <= '0;
          state_reg   <= WR_PENDING;
        end else begin
          wr_addr_reg <= wr_addr_reg + ADDR_WIDTH'(1);
          state_reg   <= WR_FILL;
        end
      end else if (swap_now) begin
        state_reg <= WR_FILL;
      end
    end
  end

  // Swap pulse and sticky frame-valid flag.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      swap_reg        <= 1'b0;
      frame_valid_reg <= 1'b0;
    end else begin
      swap_reg <= swap_now;
      if (swap_now) begin
        frame_valid_reg <= 1'b1;
      end
    end
  end

  // Read valid follows the read request with one cycle of latency.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= I_rd_en;
    end
  end

`ifdef PINGPONG_DROP_ON_BUSY_EN
  logic [DROP_COUNT_WIDTH-1:0] drop_count_reg;

  // Count frames discarded by a write during PENDING; a swap on the same edge
  // wins, so that case is not a drop. Saturates at all-ones.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      drop_count_reg <= '0;
    end else if (wr_fire && (state_reg == WR_PENDING) && !swap_now &&
                 (drop_count_reg != {DROP_COUNT_WIDTH{1'b1}})) begin
      drop_count_reg <= drop_count_reg + DROP_COUNT_WIDTH'(1);
    end
  end

  assign O_drop_count = drop_count_reg;
`endif

  assign O_swap        = swap_reg;
  assign O_frame_valid = frame_valid_reg;
  assign O_rd_valid    = rd_valid_reg;

  // One RAM bank per lane; all lanes share addresses and enables.
  generate
    for (genvar gi = 0; gi < LANE_COUNT; gi++) begin : g_lane
      frame_buffer_ram #(
        .WIDTH      (LANE_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
      ) u_ram (
        .clk     (I_clk),
        .rst     (I_rst),
        .wr_en   (wr_fire),
        .wr_sel  (ram_wr_sel),
        .wr_addr (wr_addr_reg),
        .wr_data (I_wr_data[lane_lsb(gi, LANE_WIDTH) +: LANE_WIDTH]),
        .rd_en   (I_rd_en),
        .rd_sel  (front_sel_reg),
        .rd_zero (rd_zero),
        .rd_addr (I_rd_addr),
        .rd_data (O_rd_data[lane_lsb(gi, LANE_WIDTH) +: LANE_WIDTH])
      );
    end
  endgenerate

endmodule
